// File: rtl/seq_param_rr_grant_enc_if.sv
// rtl/seq_param_rr_grant_enc_if.sv - request vector and grant handshake bundle for the round-robin encoder
// Ports (signals):
//   req        requester level vector, bit i is requester i
//   grant_val  grant_idx holds a valid winner
//   grant_idx  binary index of the winning requester
//   grant_rdy  consumer accepts the grant (fire = grant_val && grant_rdy)
// Modports: master = arbiter side, slave = requester/consumer side.
interface seq_param_rr_grant_enc_if #(
    parameter int nbits = 8
);
    localparam int iw = $clog2(nbits);

    logic [nbits-1:0] req;
    logic             grant_val;
    logic [iw-1:0]    grant_idx;
    logic             grant_rdy;

    modport master (
        input  req,
        input  grant_rdy,
        output grant_val,
        output grant_idx
    );

    modport slave (
        output req,
        output grant_rdy,
        input  grant_val,
        input  grant_idx
    );
endinterface

// File: rtl/seq_param_rr_grant_enc.sv
// rtl/seq_param_rr_grant_enc.sv - round-robin arbiter emitting a registered binary grant index
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   grant    seq_param_rr_grant_enc_if.master (req in, grant_val/grant_idx out, grant_rdy in)
module seq_param_rr_grant_enc #(
    parameter int nbits = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    seq_param_rr_grant_enc_if.master        grant
);
    localparam int iw = $clog2(nbits);
    localparam logic [iw-1:0] last_idx = iw'(nbits - 1);

    logic [iw-1:0] ptr;
    logic          val_q;
    logic [iw-1:0] idx_q;

    logic          fire;
    logic          arb_en;
    logic [iw-1:0] ptr_fire;
    logic [iw-1:0] base;
    logic          found_hi;
    logic          found_lo;
    logic [iw-1:0] win_hi;
    logic [iw-1:0] win_lo;
    logic          found;
    logic [iw-1:0] winner;

    always_comb begin
        fire     = val_q && grant.grant_rdy;
        arb_en   = !val_q || grant.grant_rdy;
        // Wrap against nbits-1 so a non power-of-two size never points past the last requester.
        ptr_fire = (idx_q == last_idx) ? '0 : idx_q + iw'(1);
        // In a fire cycle the search already starts from the post-fire pointer.
        base     = fire ? ptr_fire : ptr;

        // Two-segment scan: lowest set bit at or above base wins; otherwise the
        // lowest set bit overall (the wrapped segment). Descending loop so the
        // lowest index is the last one written.
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (grant.req[i]) begin
                found_lo = 1'b1;
                win_lo   = iw'(i);
                if (iw'(i) >= base) begin
                    found_hi = 1'b1;
                    win_hi   = iw'(i);
                end
            end
        end
        found  = found_lo;
        winner = found_hi ? win_hi : win_lo;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr   <= '0;
            val_q <= 1'b0;
            idx_q <= '0;
        end else begin
            if (fire) begin
                ptr <= ptr_fire;
            end
            // A held grant is sticky: nothing reloads until it fires.
            if (arb_en) begin
                val_q <= found;
                if (found) begin
                    idx_q <= winner;
                end
            end
        end
    end

    assign grant.grant_val = val_q;
    assign grant.grant_idx = idx_q;
endmodule

// File: tb/tb_seq_param_rr_grant_enc.sv
// tb/tb_seq_param_rr_grant_enc.sv - self-checking bench for seq_param_rr_grant_enc (nbits=5 and nbits=8)
module tb_seq_param_rr_grant_enc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst5;
    logic rst8;

    seq_param_rr_grant_enc_if #(.nbits(5)) g5 ();
    seq_param_rr_grant_enc_if #(.nbits(8)) g8 ();

    seq_param_rr_grant_enc #(.nbits(5)) dut5 (
        .clk     (clk),
        .reset_n (rst5),
        .grant   (g5.master)
    );

    seq_param_rr_grant_enc #(.nbits(8)) dut8 (
        .clk     (clk),
        .reset_n (rst8),
        .grant   (g8.master)
    );

    int errors = 0;
    int checks = 0;

    // Reference state per instance: [0] = nbits 5, [1] = nbits 8.
    int m_val [2];
    int m_idx [2];
    int m_ptr [2];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Spec-level model: modular round-robin search from the (possibly post-fire) pointer.
    function automatic void model_step(input int d, input int n, input logic rst,
                                       input logic [63:0] req, input logic rdy);
        bit arb;
        bit found;
        int w;
        if (!rst) begin
            m_val[d] = 0;
            m_idx[d] = 0;
            m_ptr[d] = 0;
            return;
        end
        arb = (m_val[d] == 0) || rdy;
        if (m_val[d] == 1 && rdy) m_ptr[d] = (m_idx[d] + 1) % n;
        if (arb) begin
            found = 0;
            w = 0;
            for (int k = 0; k < n; k++) begin
                int j;
                j = (m_ptr[d] + k) % n;
                if (!found && req[j]) begin
                    found = 1;
                    w = j;
                end
            end
            m_val[d] = found ? 1 : 0;
            if (found) m_idx[d] = w;
        end
    endfunction

    task automatic step();
        logic r5, r8, y5, y8;
        logic [63:0] q5, q8;
        r5 = rst5; r8 = rst8;
        y5 = g5.grant_rdy; y8 = g8.grant_rdy;
        q5 = 64'(g5.req); q8 = 64'(g8.req);
        @(posedge clk);
        model_step(0, 5, r5, q5, y5);
        model_step(1, 8, r8, q8, y8);
        #1;
        check_eq("val5", 64'(g5.grant_val), 64'(m_val[0]));
        check_eq("idx5", 64'(g5.grant_idx), 64'(m_idx[0]));
        check_eq("idx5_range", 64'(g5.grant_idx < 3'd5), 64'd1);
        check_eq("val8", 64'(g8.grant_val), 64'(m_val[1]));
        check_eq("idx8", 64'(g8.grant_idx), 64'(m_idx[1]));
    endtask

    int seq_a [7] = '{0, 1, 2, 3, 4, 0, 1};
    int seq_b [4] = '{0, 4, 0, 4};

    initial begin
        foreach (m_val[d]) begin
            m_val[d] = 0; m_idx[d] = 0; m_ptr[d] = 0;
        end
        rst5 = 1'b0; rst8 = 1'b0;
        g5.req = 5'b11111; g5.grant_rdy = 1'b1;
        g8.req = 8'h00;    g8.grant_rdy = 1'b0;

        // Reset held two cycles with all requests high.
        step(); step();
        check_eq("rst_val5", 64'(g5.grant_val), 64'd0);
        check_eq("rst_idx5", 64'(g5.grant_idx), 64'd0);
        check_eq("rst_val8", 64'(g8.grant_val), 64'd0);

        // Release: full-request fairness sequence, never beyond 4.
        rst5 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq("fair_val", 64'(g5.grant_val), 64'd1);
            check_eq("fair_idx", 64'(g5.grant_idx), 64'(seq_a[i]));
        end

        // Sticky hold with no ready, then request change, then fire.
        rst5 = 1'b0; step(); rst5 = 1'b1;
        g5.req = 5'b10100; g5.grant_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("hold_idx", 64'(g5.grant_idx), 64'd2);
        end
        g5.req = 5'b10000;
        step();
        check_eq("hold_drop_idx", 64'(g5.grant_idx), 64'd2);
        g5.grant_rdy = 1'b1;
        step();
        check_eq("after_fire_idx", 64'(g5.grant_idx), 64'd4);

        // Alternating 0/4 with pointer wrap at nbits-1.
        g5.req = 5'b10001;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("alt_idx", 64'(g5.grant_idx), 64'(seq_b[i]));
        end

        // Reset during a held grant.
        rst5 = 1'b0; step(); rst5 = 1'b1;
        g5.req = 5'b01000; g5.grant_rdy = 1'b0;
        step();
        check_eq("pre_rst_idx", 64'(g5.grant_idx), 64'd3);
        rst5 = 1'b0;
        step();
        check_eq("mid_rst_val", 64'(g5.grant_val), 64'd0);
        check_eq("mid_rst_idx", 64'(g5.grant_idx), 64'd0);
        rst5 = 1'b1;
        step();
        check_eq("post_rst_idx", 64'(g5.grant_idx), 64'd3);

        // nbits=8: idle with toggling ready, then wrap from 7 to 0.
        rst8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            g8.grant_rdy = i[0];
            step();
            check_eq("idle_val8", 64'(g8.grant_val), 64'd0);
        end
        g8.req = 8'h80; g8.grant_rdy = 1'b0;
        step();
        check_eq("idx8_7", 64'(g8.grant_idx), 64'd7);
        g8.req = 8'h01; g8.grant_rdy = 1'b1;
        step();
        check_eq("idx8_wrap", 64'(g8.grant_idx), 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            g5.req       = 5'($urandom);
            g8.req       = 8'($urandom);
            g5.grant_rdy = ($urandom_range(0, 9) < 7);
            g8.grant_rdy = ($urandom_range(0, 9) < 6);
            rst5         = ($urandom_range(0, 49) != 0);
            rst8         = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_param_rr_grant_enc.md
Name: seq_param_rr_grant_enc

Overview:
- Parameterized round-robin arbiter over `nbits` requesters.
- Emits the winning requester as a registered binary index with a val/rdy handshake.
- Sits directly upstream of the parameterized index-to-one-hot decoder. `grant_idx` drives the decoder's `in_`, and the decoder's `out` becomes the one-hot grant vector.
- Guarantees `grant_idx < nbits` at all times, including when `nbits` is not a power of two.

Parameters:
- nbits, 8, number of requesters. Legal range 2..64. Index width is $clog2(nbits).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- req  input  nbits  request vector; bit i is requester i. Level-sensitive; no handshake of its own.
- grant_val  output  1  grant_idx holds a valid winner.
- grant_idx  output  $clog2(nbits)  binary index of the winning requester.
- grant_rdy  input  1  consumer accepts the grant; a transfer ("fire") occurs when grant_val && grant_rdy.

Behaviour:
- Reset (reset_n == 0 at a clock edge): grant_val=0, grant_idx=0, internal priority pointer ptr=0.
  - Reset overrides any in-flight grant; a held grant is dropped with no fire.
- State: ptr (width $clog2(nbits), range 0..nbits-1), grant_val register, grant_idx register.
- Arbitration enable: arb_en = !grant_val || grant_rdy. The output register is empty or is firing this cycle.
- Winner search when arb_en:
  - Scan req starting at index ptr, ascending, wrapping from nbits-1 to 0.
  - The first set bit wins.
  - The scan never visits indices >= nbits.
- Next state when arb_en:
  - If any req bit is set: grant_val<=1, grant_idx<=winner.
  - Otherwise: grant_val<=0 and grant_idx holds its previous value.
- Hold when !arb_en (grant_val=1, grant_rdy=0): grant_val and grant_idx stay stable. They do not change even if req[grant_idx] deasserts or higher-priority requests arrive. The grant is sticky until it fires.
- Pointer update on fire only:
  - ptr <= grant_idx+1, or 0 if grant_idx == nbits-1.
  - The wrap compare is against nbits-1, not 2^width-1.
  - ptr is unchanged otherwise.
- Same-cycle fire and re-arbitration:
  - The search in a fire cycle uses the post-fire pointer (grant_idx+1, with wrap).
  - Back-to-back grants, one per cycle, are supported with no bubble.
- Latency: req sampled at edge N with the output register empty gives grant_val=1 after edge N. There is no combinational path from req or grant_rdy to any output.
- Fairness: with all requesters continuously asserting and grant_rdy=1, grants cycle 0,1,...,nbits-1,0,...
- Single requester: the same index is re-granted every cycle while its req stays high and grant_rdy=1.
- grant_rdy asserted while grant_val=0: no effect on ptr.
- Invariant: grant_idx < nbits in every cycle.

Test Plan:
- nbits=5. Hold reset_n=0 for 2 cycles with req=5'b11111 → grant_val=0, grant_idx=0. Release reset → first cycle after release has grant_val=1, grant_idx=0.
- nbits=5, req=5'b11111, grant_rdy=1 continuously → grant_idx sequence 0,1,2,3,4,0,1; never 5, 6 or 7; grant_val stays 1.
- nbits=5, req=5'b10100, grant_rdy=0 → grant_idx=2 held for 4 cycles. Drop req to 5'b10000 while holding → idx stays 2. Raise grant_rdy → next grant_idx=4.
- nbits=5, req=5'b10001, grant_rdy=1 → alternating 0,4,0,4. After idx=4 fires, ptr wraps to 0, not 5.
- nbits=5, grant idx=3, then reset_n=0 mid-hold (grant_rdy=0) → next cycle grant_val=0, grant_idx=0, ptr=0. Then req=5'b01000 → grant_idx=3.
- nbits=8, req=0 with grant_rdy toggling → grant_val stays 0, ptr unchanged. Then req=8'b10000000 → grant_idx=7; after it fires with req=8'b00000001 → grant_idx=0.
